// File: rtl/cic_sched_pkg.sv
// Shared types for the CIC stream scheduler: channel identifier and FSM state.
package cic_sched_pkg;

    localparam int NCH_MAX = 16;

    typedef logic [$clog2(NCH_MAX)-1:0] chan_id_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_t;

endpackage

// File: rtl/cic_stream_scheduler_if.sv
// Stream-side bundle of the scheduler: per-channel requests, decimator in/out and tagged output.
interface cic_stream_scheduler_if #(
    parameter int NCH       = 4,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 24
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]          req_valid;
    logic [NCH-1:0]          req_ready;
    logic [NCH*IN_WIDTH-1:0] req_data;
    logic                    cic_in_valid;
    logic                    cic_in_ready;
    logic [IN_WIDTH-1:0]     cic_in_data;
    logic                    cic_out_valid;
    logic                    cic_out_ready;
    logic [OUT_WIDTH-1:0]    cic_out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_WIDTH-1:0]    out_data;
    logic [CW-1:0]           out_chan;

    modport master (
        input  req_valid, req_data, cic_in_ready, cic_out_valid, cic_out_data, out_ready,
        output req_ready, cic_in_valid, cic_in_data, cic_out_ready, out_valid, out_data, out_chan
    );

    modport slave (
        output req_valid, req_data, cic_in_ready, cic_out_valid, cic_out_data, out_ready,
        input  req_ready, cic_in_valid, cic_in_data, cic_out_ready, out_valid, out_data, out_chan
    );

endinterface

// File: rtl/cic_tag_fifo.sv
// Small synchronous FIFO holding the channel ID of every burst still inside the decimator.
module cic_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             in_clock,
    input  logic             in_reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == FULL_CNT);
    assign empty    = (count_reg == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/cic_stream_scheduler.sv
// Round-robin burst scheduler sharing one CIC decimator across NCH streams, tagging each output
// with the channel whose R-sample frame produced it.
module cic_stream_scheduler
    import cic_sched_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int R         = 8,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 24,
    parameter int TAG_DEPTH = 4
) (
    input  logic                   in_clock,
    input  logic                   in_reset_n,
    input  logic                   in_enable,
    cic_stream_scheduler_if.master bus,
    output logic                   busy,
    output logic                   tag_err
);
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = (R > 1) ? $clog2(R) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(R - 1);
    localparam logic [CW-1:0]    RR_INIT  = CW'(NCH - 1);

    sched_state_t        state_reg;
    logic [CW-1:0]       rr_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                tag_err_reg;

    logic                tag_full;
    logic                tag_empty;
    logic                tag_push;
    logic                tag_pop;
    logic [CW-1:0]       tag_head;
    logic [CW-1:0]       winner;
    logic                any_req;
    logic                in_hs;
    logic [IN_WIDTH-1:0] chan_data [NCH];
    logic [OUT_WIDTH-1:0] out_data_w;

    // First valid channel strictly after 'last', wrapping modulo NCH.
    function automatic logic [CW-1:0] rr_pick(input logic [NCH-1:0] v, input logic [CW-1:0] last);
        logic [CW-1:0] pick;
        logic [CW-1:0] ci;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(last) + i) % NCH;
            ci  = CW'(idx);
            if (!found && v[ci]) begin
                pick  = ci;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign any_req  = |bus.req_valid;
    assign winner   = rr_pick(bus.req_valid, rr_reg);
    assign tag_push = (state_reg == IDLE) && in_enable && any_req && !tag_full;
    assign busy     = (state_reg == BURST);
    assign tag_err  = tag_err_reg;

    // rr_reg doubles as the granted channel while a burst is running.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        assign chan_data[gi]     = bus.req_data[gi*IN_WIDTH +: IN_WIDTH];
        assign bus.req_ready[gi] = busy && (rr_reg == CW'(gi)) && bus.cic_in_ready;
    end

    assign bus.cic_in_valid = busy && bus.req_valid[rr_reg];
    assign bus.cic_in_data  = chan_data[rr_reg];
    assign in_hs            = bus.cic_in_valid && bus.cic_in_ready;

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_reg   <= IDLE;
            rr_reg      <= RR_INIT;
            cnt_reg     <= '0;
            tag_err_reg <= 1'b0;
        end else begin
            if (bus.cic_out_valid && tag_empty) begin
                tag_err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (tag_push) begin
                        rr_reg    <= winner;
                        cnt_reg   <= '0;
                        state_reg <= BURST;
                    end
                end
                BURST: begin
                    if (in_hs) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == LAST_CNT) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // An untagged decimator sample is held (ready low) rather than dropped.
    assign out_data_w        = bus.cic_out_data;
    assign bus.out_valid     = bus.cic_out_valid && !tag_empty;
    assign bus.cic_out_ready = bus.out_ready && !tag_empty;
    assign bus.out_data      = out_data_w;
    assign bus.out_chan      = tag_empty ? '0 : tag_head;
    assign tag_pop           = bus.out_valid && bus.out_ready;

    cic_tag_fifo #(
        .WIDTH (CW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .in_clock   (in_clock),
        .in_reset_n (in_reset_n),
        .push       (tag_push),
        .push_data  (winner),
        .pop        (tag_pop),
        .pop_data   (tag_head),
        .full       (tag_full),
        .empty      (tag_empty)
    );

endmodule

// File: tb/tb_cic_stream_scheduler.sv
// Directed bench for cic_stream_scheduler with a behavioural decimator that sums each R-sample frame.
module tb_cic_stream_scheduler;
  localparam int NCH = 4;
  localparam int R   = 8;
  localparam int IW  = 16;
  localparam int OW  = 24;
  localparam int TD  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en    = 1'b0;
  logic busy;
  logic tag_err;
  logic inject = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  cic_stream_scheduler_if #(.NCH(NCH), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  cic_stream_scheduler #(
    .NCH(NCH), .R(R), .IN_WIDTH(IW), .OUT_WIDTH(OW), .TAG_DEPTH(TD)
  ) dut (
    .in_clock   (clk),
    .in_reset_n (rst_n),
    .in_enable  (en),
    .bus        (bus),
    .busy       (busy),
    .tag_err    (tag_err)
  );

  always #5 clk = ~clk;

  // Behavioural decimator: sums R accepted samples into one queued output.
  logic [OW-1:0] dq [16];
  logic [4:0]    dq_wr, dq_rd;
  logic [OW-1:0] acc;
  int frame_n, nb, no, onehot_err, cur_chan;
  int cyc = 0;
  int hs_chan [NCH];
  int burst_chan [32];
  int burst_start [32];
  int out_chan_log [32];
  logic [OW-1:0] out_data_log [32];

  assign bus.cic_out_valid = (dq_wr != dq_rd);
  assign bus.cic_out_data  = dq[dq_rd[3:0]];

  function automatic int ch_of(input logic [NCH-1:0] v);
    int r;
    r = -1;
    for (int i = NCH - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_wr <= '0; dq_rd <= '0; acc <= '0;
      frame_n <= 0; nb <= 0; no <= 0; onehot_err <= 0; cur_chan <= 0;
      for (int c = 0; c < NCH; c++) hs_chan[c] <= 0;
    end else begin
      if (!(bus.req_ready == '0 || $onehot(bus.req_ready))) onehot_err <= onehot_err + 1;
      if (bus.cic_in_valid && bus.cic_in_ready) begin
        if (ch_of(bus.req_ready) >= 0) hs_chan[ch_of(bus.req_ready)] <= hs_chan[ch_of(bus.req_ready)] + 1;
        if (frame_n == 0 && nb < 32) begin
          burst_chan[nb]  <= ch_of(bus.req_ready);
          burst_start[nb] <= cyc;
          nb              <= nb + 1;
          cur_chan        <= ch_of(bus.req_ready);
        end
        if (frame_n == R - 1) begin
          dq[dq_wr[3:0]] <= acc + OW'(bus.cic_in_data);
          dq_wr          <= dq_wr + 1'b1;
          acc            <= '0;
          frame_n        <= 0;
        end else begin
          acc     <= acc + OW'(bus.cic_in_data);
          frame_n <= frame_n + 1;
        end
      end
      if (inject) begin
        dq[dq_wr[3:0]] <= 24'hABCDEF;
        dq_wr          <= dq_wr + 1'b1;
      end
      if (bus.cic_out_valid && bus.cic_out_ready) dq_rd <= dq_rd + 1'b1;
      if (bus.out_valid && bus.out_ready && no < 32) begin
        out_chan_log[no] <= int'(bus.out_chan);
        out_data_log[no] <= bus.out_data;
        no               <= no + 1;
        $display("out %0d: chan=%0d data=%0d", no, bus.out_chan, bus.out_data);
      end
    end
  end

  task automatic set_data(input int base, input int step);
    for (int c = 0; c < NCH; c++) bus.req_data[c*IW +: IW] = IW'(base + step * c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; inject = 1'b0;
    bus.req_valid = '0; bus.out_ready = 1'b1; bus.cic_in_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.req_valid = '0; bus.out_ready = 1'b1; bus.cic_in_ready = 1'b1; set_data(0, 0);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 4'b0) $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.cic_in_valid !== 1'b0) $display("FAIL reset_cic_in_valid: got %b want 0", bus.cic_in_valid); else pass_cnt++;
    total_cnt++; if (bus.cic_out_ready !== 1'b0) $display("FAIL reset_cic_out_ready: got %b want 0", bus.cic_out_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_chan !== 2'd0) $display("FAIL reset_out_chan: got %0d want 0", bus.out_chan); else pass_cnt++;
    total_cnt++; if (tag_err !== 1'b0) $display("FAIL reset_tag_err: got %b want 0", tag_err); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = '1;
    repeat (5) @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL disabled_no_grant: busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 4'b0) $display("FAIL disabled_req_ready: got %b want 0000", bus.req_ready); else pass_cnt++;
  endtask

  task automatic test_single_channel();
    do_reset();
    set_data(0, 0);
    bus.req_data[0*IW +: IW] = 16'd111;
    bus.req_data[1*IW +: IW] = 16'd222;
    bus.req_data[2*IW +: IW] = 16'd1000;
    bus.req_data[3*IW +: IW] = 16'd333;
    bus.req_valid = 4'b0100; en = 1'b1;
    for (int i = 0; i < 100 && no < 2; i++) @(negedge clk);
    total_cnt++; if (no < 2) $display("FAIL single_timeout: outputs got %0d want 2", no); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      total_cnt++; if (out_chan_log[i] != 2) $display("FAIL single_chan%0d: got %0d want 2", i, out_chan_log[i]); else pass_cnt++;
      total_cnt++; if (out_data_log[i] !== 24'd8000) $display("FAIL single_data%0d: got %0d want 8000", i, out_data_log[i]); else pass_cnt++;
      total_cnt++; if (burst_chan[i] != 2) $display("FAIL single_grant%0d: got %0d want 2", i, burst_chan[i]); else pass_cnt++;
    end
    total_cnt++;
    if (hs_chan[0] + hs_chan[1] + hs_chan[3] != 0) $display("FAIL single_other_hs: got %0d want 0", hs_chan[0] + hs_chan[1] + hs_chan[3]);
    else pass_cnt++;
    bus.req_valid = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    set_data(100, 100);
    bus.req_valid = '1; en = 1'b1;
    for (int i = 0; i < 150 && (nb < 5 || no < 4); i++) @(negedge clk);
    total_cnt++; if (nb < 5 || no < 4) $display("FAIL rr_timeout: bursts %0d outputs %0d want 5/4", nb, no); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (burst_chan[i] != i % NCH) $display("FAIL rr_order%0d: got %0d want %0d", i, burst_chan[i], i % NCH); else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (burst_start[i+1] - burst_start[i] != R + 1) $display("FAIL rr_spacing%0d: got %0d want %0d", i, burst_start[i+1] - burst_start[i], R + 1);
      else pass_cnt++;
      total_cnt++; if (out_chan_log[i] != i) $display("FAIL rr_tag%0d: got %0d want %0d", i, out_chan_log[i], i); else pass_cnt++;
      total_cnt++;
      if (out_data_log[i] !== OW'((i + 1) * 100 * R)) $display("FAIL rr_data%0d: got %0d want %0d", i, out_data_log[i], (i + 1) * 100 * R);
      else pass_cnt++;
    end
    total_cnt++; if (onehot_err != 0) $display("FAIL rr_onehot: violations got %0d want 0", onehot_err); else pass_cnt++;
    bus.req_valid = '0;
  endtask

  task automatic test_stall();
    bit stalled;
    do_reset();
    set_data(10, 1);
    stalled = 1'b0;
    bus.req_valid = 4'b0111; en = 1'b1;
    for (int i = 0; i < 200 && nb < 3; i++) begin
      @(negedge clk);
      if (!stalled && nb == 2 && cur_chan == 1 && frame_n == 3) begin
        stalled = 1'b1;
        bus.req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL stall_busy: got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (bus.cic_in_valid !== 1'b0) $display("FAIL stall_in_valid: got %b want 0", bus.cic_in_valid); else pass_cnt++;
        total_cnt++; if (bus.req_ready !== 4'b0010) $display("FAIL stall_req_ready: got %b want 0010", bus.req_ready); else pass_cnt++;
        repeat (2) @(negedge clk);
        bus.req_valid[1] = 1'b1;
      end
    end
    total_cnt++; if (!stalled || nb < 3) $display("FAIL stall_timeout: stalled %0d bursts %0d want 1/3", stalled, nb); else pass_cnt++;
    total_cnt++; if (burst_chan[1] != 1) $display("FAIL stall_grant1: got %0d want 1", burst_chan[1]); else pass_cnt++;
    total_cnt++; if (burst_chan[2] != 2) $display("FAIL stall_grant2: got %0d want 2", burst_chan[2]); else pass_cnt++;
    total_cnt++; if (hs_chan[1] != R) $display("FAIL stall_hs_count: got %0d want %0d", hs_chan[1], R); else pass_cnt++;
    total_cnt++;
    if (burst_start[2] - burst_start[1] != R + 1 + 5) $display("FAIL stall_gap: got %0d want %0d", burst_start[2] - burst_start[1], R + 6);
    else pass_cnt++;
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_data(1, 1);
    bus.out_ready = 1'b0; bus.req_valid = '1; en = 1'b1;
    repeat (60) @(negedge clk);
    total_cnt++; if (nb != TD) $display("FAIL bp_bursts: got %0d want %0d", nb, TD); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL bp_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 4'b0) $display("FAIL bp_req_ready: got %b want 0000", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b want 1", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_chan !== 2'd0) $display("FAIL bp_head: got %0d want 0", bus.out_chan); else pass_cnt++;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && (no < 4 || nb < 5); i++) @(negedge clk);
    total_cnt++; if (no < 4 || nb < 5) $display("FAIL bp_timeout: outputs %0d bursts %0d want 4/5", no, nb); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (out_chan_log[i] != i) $display("FAIL bp_drain%0d: got %0d want %0d", i, out_chan_log[i], i); else pass_cnt++;
    end
    total_cnt++; if (burst_chan[4] != 0) $display("FAIL bp_resume: got %0d want 0", burst_chan[4]); else pass_cnt++;
    bus.req_valid = '0;
  endtask

  task automatic test_enable();
    do_reset();
    set_data(5, 5);
    bus.req_valid = '1; en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (nb == 1 && cur_chan == 0 && frame_n == 4) break;
    end
    total_cnt++; if (frame_n != 4) $display("FAIL en_reach: frame sample got %0d want 4", frame_n); else pass_cnt++;
    en = 1'b0;
    repeat (30) @(negedge clk);
    total_cnt++; if (nb != 1) $display("FAIL en_no_grant: bursts got %0d want 1", nb); else pass_cnt++;
    total_cnt++; if (hs_chan[0] != R) $display("FAIL en_full_burst: got %0d want %0d", hs_chan[0], R); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL en_busy: got %b want 0", busy); else pass_cnt++;
    en = 1'b1;
    for (int i = 0; i < 20 && nb < 2; i++) @(negedge clk);
    total_cnt++; if (nb < 2 || burst_chan[1] != 1) $display("FAIL en_next: bursts %0d chan %0d want 2/1", nb, burst_chan[1]); else pass_cnt++;
    bus.req_valid = '0;
  endtask

  task automatic test_tag_err();
    do_reset();
    en = 1'b1; bus.req_valid = '0;
    total_cnt++; if (tag_err !== 1'b0) $display("FAIL terr_clear: got %b want 0", tag_err); else pass_cnt++;
    @(negedge clk); inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    @(negedge clk);
    total_cnt++; if (tag_err !== 1'b1) $display("FAIL terr_set: got %b want 1", tag_err); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL terr_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.cic_out_ready !== 1'b0) $display("FAIL terr_ready: got %b want 0", bus.cic_out_ready); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (tag_err !== 1'b1) $display("FAIL terr_sticky: got %b want 1", tag_err); else pass_cnt++;
    total_cnt++; if (bus.cic_out_valid !== 1'b1) $display("FAIL terr_held: got %b want 1", bus.cic_out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    set_data(100, 100);
    bus.req_valid = '1; en = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (nb == 1 && cur_chan == 0 && frame_n == 5) break;
    end
    total_cnt++; if (frame_n != 5) $display("FAIL mid_reach: frame sample got %0d want 5", frame_n); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 4'b0) $display("FAIL mid_req_ready: got %b want 0000", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.cic_in_valid !== 1'b0) $display("FAIL mid_in_valid: got %b want 0", bus.cic_in_valid); else pass_cnt++;
    total_cnt++; if (bus.cic_out_ready !== 1'b0) $display("FAIL mid_out_ready: got %b want 0", bus.cic_out_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_chan !== 2'd0) $display("FAIL mid_out_chan: got %0d want 0", bus.out_chan); else pass_cnt++;
    total_cnt++; if (tag_err !== 1'b0) $display("FAIL mid_tag_err: got %b want 0", tag_err); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL mid_tags_empty: out_valid got %b want 0", bus.out_valid); else pass_cnt++;
    for (int i = 0; i < 40 && no < 1; i++) @(negedge clk);
    total_cnt++; if (no < 1) $display("FAIL mid_timeout: outputs got %0d want 1", no); else pass_cnt++;
    total_cnt++; if (burst_chan[0] != 0) $display("FAIL mid_first_grant: got %0d want 0", burst_chan[0]); else pass_cnt++;
    total_cnt++; if (out_chan_log[0] != 0) $display("FAIL mid_first_tag: got %0d want 0", out_chan_log[0]); else pass_cnt++;
    total_cnt++; if (out_data_log[0] !== 24'd800) $display("FAIL mid_first_data: got %0d want 800", out_data_log[0]); else pass_cnt++;
    total_cnt++; if (tag_err !== 1'b0) $display("FAIL mid_tag_err_after: got %b want 0", tag_err); else pass_cnt++;
    bus.req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_stall();
    test_backpressure();
    test_enable();
    test_tag_err();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
